// File: rtl/locking_arb_pkg.sv
// Shared helpers for the locking round-robin arbiter: width derivation and
// the lock FSM state encoding.
package locking_arb_pkg;

    // Lock FSM: either free-running round robin or holding one input.
    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Index/counter width that never collapses to zero bits.
    function automatic int idx_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/rr_pick_n.sv
// Combinational round-robin pick: lowest valid index above last_grant,
// otherwise lowest valid index overall, otherwise N-1 when nothing is valid.
module rr_pick_n #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [CW-1:0] last_grant,
    output logic [CW-1:0] choice
);

    // Two descending scans so the lowest matching index is written last;
    // the "above last_grant" scan runs second and therefore takes priority.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        choice = CW'(N - 1);
        for (int i = N - 1; i >= 0; i--) begin
            if (valid[i]) begin
                choice = CW'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (valid[i] && (i > int'(last_grant))) begin
                choice = CW'(i);
            end
        end
    end

endmodule

// File: rtl/locking_rr_arbiter_n.sv
// N-input round-robin arbiter that holds its grant for a whole BEATS-beat
// message once a multi-beat transfer wins. Chosen index and lock status are
// exported; nothing on the output side depends combinationally on io_out_ready.
module locking_rr_arbiter_n
    import locking_arb_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = 32,
    parameter  int BEATS = 4,
    localparam int CW    = idx_width(N),
    localparam int BW    = idx_width(BEATS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    io_in_valid,
    output logic [N-1:0]    io_in_ready,
    input  logic [N*W-1:0]  io_in_bits,
    input  logic [N-1:0]    io_in_multibeat,
    input  logic            io_out_ready,
    output logic            io_out_valid,
    output logic [W-1:0]    io_out_bits,
    output logic [CW-1:0]   io_chosen,
    output logic            io_locked
);

    localparam logic          LOCK_EN   = (BEATS > 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    lock_state_e   state, state_next;
    logic [CW-1:0] last_grant, last_grant_next;
    logic [CW-1:0] lock_idx, lock_idx_next;
    logic [BW-1:0] beat_cnt, beat_cnt_next;
    logic [CW-1:0] pick;
    logic [CW-1:0] chosen;
    logic          out_valid;
    logic          fire;

    rr_pick_n #(
        .N  (N),
        .CW (CW)
    ) u_pick (
        .valid      (io_in_valid),
        .last_grant (last_grant),
        .choice     (pick)
    );

    // State register: reset puts input 0 first in line and drops any lock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_UNLOCKED;
            last_grant <= CW'(N - 1);
            lock_idx   <= '0;
            beat_cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state      <= state_next;
            last_grant <= last_grant_next;
            lock_idx   <= lock_idx_next;
            beat_cnt   <= beat_cnt_next;
        end
    end

    // Next state: only a completed transfer moves the pointer or the lock.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        lock_idx_next   = lock_idx;
        beat_cnt_next   = beat_cnt;
        if (fire) begin
            last_grant_next = chosen;
            case (state)
                ST_UNLOCKED: begin
                    // Multibeat flag matters only on the first beat.
                    if (LOCK_EN && io_in_multibeat[chosen]) begin
                        state_next    = ST_LOCKED;
                        lock_idx_next = chosen;
                        beat_cnt_next = BW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (beat_cnt == LAST_BEAT) begin
                        state_next    = ST_UNLOCKED;
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: select the channel, mux its payload/valid, and steer ready.
    always_comb begin
        chosen      = (state == ST_LOCKED) ? lock_idx : pick;
        out_valid   = 1'b0;
        io_out_bits = '0;
        io_in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (chosen == CW'(i)) begin
                out_valid      = io_in_valid[i];
                io_out_bits    = io_in_bits[i*W +: W];
                io_in_ready[i] = io_out_ready;
            end
        end
    end

    assign fire         = out_valid & io_out_ready;
    assign io_out_valid = out_valid;
    assign io_chosen    = chosen;
    assign io_locked    = (state == ST_LOCKED);

endmodule

// File: tb/tb_locking_rr_arbiter_n.sv
// Bench for locking_rr_arbiter_n: a 4-input/4-beat instance driven by a
// directed vector table plus random traffic, and a 5-input/8-bit/1-beat
// instance checked as a plain round-robin arbiter.
module tb_locking_rr_arbiter_n;

    localparam int NA = 4;
    localparam int WA = 32;
    localparam int BA = 4;
    localparam int NB = 5;
    localparam int WB = 8;

    typedef struct {
        logic [NA-1:0] valid;
        logic [NA-1:0] mb;
        logic          rdy;
        int            chosen;
        logic          locked;
        logic          ovalid;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic [NA-1:0]    a_valid, a_ready, a_mb;
    logic [NA*WA-1:0] a_bits;
    logic             a_oready, a_ovalid, a_locked;
    logic [WA-1:0]    a_obits;
    logic [1:0]       a_chosen;

    // Instance B signals
    logic [NB-1:0]    b_valid, b_ready, b_mb;
    logic [NB*WB-1:0] b_bits;
    logic             b_oready, b_ovalid, b_locked;
    logic [WB-1:0]    b_obits;
    logic [2:0]       b_chosen;

    locking_rr_arbiter_n #(.N(NA), .W(WA), .BEATS(BA)) u_a (
        .clk             (clk),
        .reset           (reset),
        .io_in_valid     (a_valid),
        .io_in_ready     (a_ready),
        .io_in_bits      (a_bits),
        .io_in_multibeat (a_mb),
        .io_out_ready    (a_oready),
        .io_out_valid    (a_ovalid),
        .io_out_bits     (a_obits),
        .io_chosen       (a_chosen),
        .io_locked       (a_locked)
    );

    locking_rr_arbiter_n #(.N(NB), .W(WB), .BEATS(1)) u_b (
        .clk             (clk),
        .reset           (reset),
        .io_in_valid     (b_valid),
        .io_in_ready     (b_ready),
        .io_in_bits      (b_bits),
        .io_in_multibeat (b_mb),
        .io_out_ready    (b_oready),
        .io_out_valid    (b_ovalid),
        .io_out_bits     (b_obits),
        .io_chosen       (b_chosen),
        .io_locked       (b_locked)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: last granted index, beats still owed by the
    // current locked message (0 = free), and which input owns the lock.
    int a_last, a_rem, a_idx;
    int b_last;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Cyclic search starting just after the last grant.
    function automatic int rr_ref(input int n, input int last, input logic [7:0] v);
        int idx;
        for (int k = 1; k <= n; k++) begin
            idx = (last + k) % n;
            if (v[idx]) return idx;
        end
        return n - 1;
    endfunction

    task automatic model_reset();
        a_last = NA - 1;
        a_rem  = 0;
        a_idx  = 0;
        b_last = NB - 1;
    endtask

    task automatic add(input logic [3:0] v, input logic [3:0] mb, input logic r,
                       input int c, input logic l, input logic ov);
        vec_t e;
        e.valid = v; e.mb = mb; e.rdy = r; e.chosen = c; e.locked = l; e.ovalid = ov;
        tbl.push_back(e);
    endtask

    // One cycle on instance A: drive at negedge, compare against the model,
    // then advance the model across the rising edge.
    task automatic step_a(input logic [NA-1:0] v, input logic [NA-1:0] mb, input logic rdy,
                          input string tag, output int obs_c, output logic obs_l,
                          output logic obs_v);
        int            exp_c;
        logic          exp_l, exp_v;
        logic [NA-1:0] exp_r;
        @(negedge clk);
        a_valid  = v;
        a_mb     = mb;
        a_oready = rdy;
        a_bits   = {$urandom, $urandom, $urandom, $urandom};
        #1;
        exp_l = (a_rem > 0);
        exp_c = exp_l ? a_idx : rr_ref(NA, a_last, {4'b0, v});
        exp_v = v[exp_c];
        exp_r = rdy ? NA'(1 << exp_c) : '0;
        check({tag, "_chosen"}, a_chosen, exp_c);
        check({tag, "_locked"}, a_locked, exp_l);
        check({tag, "_ovalid"}, a_ovalid, exp_v);
        check({tag, "_ready"},  a_ready,  exp_r);
        check({tag, "_bits"},   a_obits,  a_bits[exp_c*WA +: WA]);
        obs_c = int'(a_chosen);
        obs_l = a_locked;
        obs_v = a_ovalid;
        @(posedge clk);
        if (exp_v && rdy) begin
            a_last = exp_c;
            if (a_rem > 0) begin
                a_rem--;
            end else if (mb[exp_c]) begin
                a_rem = BA - 1;
                a_idx = exp_c;
            end
        end
    endtask

    // One cycle on instance B (single-beat build: plain round robin).
    task automatic step_b(input logic [NB-1:0] v, input logic [NB-1:0] mb, input logic rdy,
                          input string tag, output int obs_c);
        int            exp_c;
        logic [NB-1:0] exp_r;
        @(negedge clk);
        b_valid  = v;
        b_mb     = mb;
        b_oready = rdy;
        b_bits   = {$urandom, 8'($urandom)};
        #1;
        exp_c = rr_ref(NB, b_last, {3'b0, v});
        exp_r = rdy ? NB'(1 << exp_c) : '0;
        check({tag, "_chosen"}, b_chosen, exp_c);
        check({tag, "_locked"}, b_locked, 1'b0);
        check({tag, "_ovalid"}, b_ovalid, v[exp_c]);
        check({tag, "_ready"},  b_ready,  exp_r);
        check({tag, "_bits"},   b_obits,  b_bits[exp_c*WB +: WB]);
        obs_c = int'(b_chosen);
        @(posedge clk);
        if (v[exp_c] && rdy) b_last = exp_c;
    endtask

    initial begin
        int   c;
        logic l, ov;

        // Directed table for instance A (expected values worked by hand).
        add(4'b0000, 4'b0000, 1'b0, 3, 1'b0, 1'b0);   // reset state: nothing valid
        for (int k = 0; k < 5; k++)                     // round robin 0,1,2,3,0
            add(4'b1111, 4'b0000, 1'b1, k % 4, 1'b0, 1'b1);
        add(4'b0110, 4'b0010, 1'b1, 1, 1'b0, 1'b1);   // lock entry on input 1
        for (int k = 0; k < 3; k++)
            add(4'b0110, 4'b0010, 1'b1, 1, 1'b1, 1'b1);
        add(4'b0110, 4'b0000, 1'b1, 2, 1'b0, 1'b1);   // released, RR moves on
        add(4'b0110, 4'b0010, 1'b1, 1, 1'b0, 1'b1);   // lock input 1 again
        add(4'b0110, 4'b0010, 1'b1, 1, 1'b1, 1'b1);   // second beat
        for (int k = 0; k < 3; k++)                     // backpressure holds
            add(4'b0110, 4'b0000, 1'b0, 1, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++)
            add(4'b0110, 4'b0000, 1'b1, 1, 1'b1, 1'b1);
        add(4'b0110, 4'b0000, 1'b1, 2, 1'b0, 1'b1);
        add(4'b1000, 4'b1000, 1'b1, 3, 1'b0, 1'b1);   // lock input 3
        for (int k = 0; k < 2; k++)                     // holder drops valid
            add(4'b0001, 4'b0000, 1'b1, 3, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            add(4'b1001, 4'b0000, 1'b1, 3, 1'b1, 1'b1);
        add(4'b1001, 4'b0000, 1'b1, 0, 1'b0, 1'b1);   // wraps to 0 after unlock
        add(4'b0000, 4'b0000, 1'b1, 3, 1'b0, 1'b0);   // idle

        a_valid = '0; a_mb = '0; a_oready = 1'b0; a_bits = '0;
        b_valid = '0; b_mb = '0; b_oready = 1'b0; b_bits = '0;
        model_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            step_a(tbl[i].valid, tbl[i].mb, tbl[i].rdy, $sformatf("tbl%0d", i), c, l, ov);
            check($sformatf("tbl%0d_vec_chosen", i), c, tbl[i].chosen);
            check($sformatf("tbl%0d_vec_locked", i), l, tbl[i].locked);
            check($sformatf("tbl%0d_vec_ovalid", i), ov, tbl[i].ovalid);
        end

        // Asynchronous reset in the middle of a locked message.
        step_a(4'b0100, 4'b0100, 1'b1, "arst_lock", c, l, ov);
        step_a(4'b0100, 4'b0000, 1'b0, "arst_hold", c, l, ov);
        check("arst_pre_locked", l, 1'b1);
        @(negedge clk);
        #2;
        reset   = 1'b0;
        a_valid = 4'b1001;
        #1;
        check("arst_locked", a_locked, 1'b0);
        check("arst_chosen", a_chosen, 0);
        model_reset();
        #1;
        reset = 1'b1;
        step_a(4'b1001, 4'b0000, 1'b1, "post_rst", c, l, ov);
        check("post_rst_vec_chosen", c, 0);

        // Random traffic on instance A.
        for (int k = 0; k < 400; k++) begin
            step_a(NA'($urandom), NA'($urandom & $urandom), ($urandom % 4) != 0,
                   $sformatf("rnd_a%0d", k), c, l, ov);
        end

        // Instance B: every input valid and flagged multibeat never locks.
        for (int k = 0; k < 12; k++) begin
            step_b(5'h1F, 5'h1F, 1'b1, $sformatf("b_rr%0d", k), c);
            check($sformatf("b_rr%0d_order", k), c, k % NB);
        end
        for (int k = 0; k < 200; k++) begin
            step_b(NB'($urandom), NB'($urandom), ($urandom % 4) != 0,
                   $sformatf("rnd_b%0d", k), c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
